uart_tx_feeder: RTL
===================

# uart_tx_feeder

Byte buffer and launch controller that sits directly upstream of the UART transmitter. Producers (ALU result path, command responder) push bytes into a circular FIFO; the controller pops one byte at a time, presents it on `din` with a one-cycle `tx_start` pulse, then holds until the transmitter returns `tx_done_tick`. It decouples bursty producers from the slow serial line and guarantees the transmitter never sees `tx_start` while it is mid-frame.

## Interface
- `DBIT`, 8, data width in bits; must match the transmitter's `DBIT`.
- `ADDR_W`, 4, FIFO address width; depth = 2^ADDR_W entries (16 by default).
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `wr`  in  1  push strobe; one byte per high cycle.
- `w_data`  in  DBIT  byte to push; sampled when `wr`=1.
- `full`  out  1  FIFO holds 2^ADDR_W entries.
- `empty`  out  1  FIFO holds 0 entries.
- `count`  out  ADDR_W+1  current occupancy, 0..2^ADDR_W.
- `overflow`  out  1  sticky; set by a rejected push.
- `tx_start`  out  1  one-cycle launch pulse to the transmitter.
- `din`  out  DBIT  byte for the transmitter; valid whenever `tx_start`=1 and held until the next launch.
- `tx_done_tick`  in  1  end-of-frame pulse from the transmitter.
- `busy`  out  1  a frame is in flight (state WAIT).

## Operation
- FIFO:
  - Circular buffer with `rd_ptr` and `wr_ptr` of ADDR_W bits each, both wrapping modulo 2^ADDR_W.
  - `count` is a registered ADDR_W+1 counter.
  - `full` = (`count` == 2^ADDR_W). `empty` = (`count` == 0).
- Push is accepted when `wr`=1 and either `full`=0 or a pop occurs in the same cycle.
  - An accepted push writes `mem[wr_ptr]` and increments `wr_ptr`.
  - A rejected push leaves storage unchanged and sets `overflow` to 1. `overflow` clears only on reset.
- A pop occurs only in IDLE when `empty`=0. It increments `rd_ptr`.
- `count`: +1 on push only, -1 on pop only, unchanged when both or neither occur.
- Controller FSM, two states:
  - IDLE, when `empty`=0: register `din` <= `mem[rd_ptr]`, register `tx_start` <= 1, pop, go to WAIT.
  - IDLE, when `empty`=1: remain in IDLE, `tx_start` <= 0.
  - WAIT: `tx_start` <= 0. When `tx_done_tick`=1, go to IDLE; otherwise stay in WAIT.
- `tx_done_tick` is ignored in IDLE.
- `busy` = (state == WAIT).
- Reset values:
  - state IDLE; `rd_ptr`, `wr_ptr`, `count` = 0.
  - `tx_start` = 0, `din` = 0, `overflow` = 0.
  - Therefore `empty` = 1, `full` = 0, `busy` = 0.
  - FIFO memory contents are not reset.
- Reset mid-frame discards all buffered bytes. The transmitter shares `reset`, so both return to idle together.

## Timing
- Push-to-launch latency: `wr` high in cycle k, with IDLE and FIFO empty, gives `tx_start` high in cycle k+2. `empty` falls in cycle k+1.
- `tx_start` is high for exactly one cycle per popped byte and is never high in two consecutive cycles.
- `din` changes only at the edge that raises `tx_start`, so it is stable for the whole frame.
- Back-to-back frames: `tx_done_tick` in cycle d gives IDLE in d+1 and the next `tx_start` in d+2. The transmitter is in its idle state at d+1 and d+2, so the pulse is never lost.
- Push and pop in the same cycle at `count` = 2^ADDR_W: both are accepted, `count` stays at 2^ADDR_W, and `overflow` is not set.
- Push into an empty FIFO never bypasses: data becomes poppable the cycle after it is written.
- `full`, `empty` and `count` are glitch-free registered-derived outputs.

## Structure
- Shared package `uart_pkg`:
  - State encoding constants ST_IDLE = 1'b0 and ST_WAIT = 1'b1.
  - Default `DBIT` = 8.
  - Default `ADDR_W` = 4.
- One sub-module, `fifo_sync`. It holds the storage, pointers, `count`, `full`, `empty` and `overflow`, with ports `wr`/`w_data`/`rd`/`r_data`.
- The top level contains the FSM, the `din` register and the `tx_start` register, and instantiates `fifo_sync`.

## Test plan
- Reset, then push 8'hA5 at cycle 10:
  - `empty` falls at cycle 11, `tx_start` pulses at cycle 12 with `din` = 8'hA5, `busy` = 1.
  - `tx_done_tick` at cycle 200 gives `busy` = 0 at cycle 201.
- Push 8'h01, 8'h02, 8'h03 on consecutive cycles, then model the transmitter with `tx_done_tick` 50 cycles after each `tx_start`:
  - Exactly three `tx_start` pulses, `din` in order 01, 02, 03.
  - Each next pulse arrives 2 cycles after the previous `tx_done_tick`.
- Hold `tx_done_tick` low and push 17 bytes 8'h00..8'h10:
  - The first byte is popped into `din`.
  - All 16 remaining bytes are accepted, `full` = 1, `count` = 16, `overflow` = 0.
  - An 18th push sets `overflow` = 1 and `count` stays 16.
- From the full state, push 8'hEE in the same cycle as a pop:
  - `count` stays 16, `overflow` stays 0.
  - 8'hEE is the last byte transmitted.
- Pulse `tx_done_tick` while IDLE and empty:
  - No state change and no `tx_start`.
  - Assert `reset` in WAIT with 5 bytes buffered: `count` = 0, `empty` = 1, `tx_start` = 0, `busy` = 0 immediately, and no launch after reset release.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and defaults for the UART transmit path.
package uart_pkg;

    localparam int unsigned DEF_DBIT   = 8;
    localparam int unsigned DEF_ADDR_W = 4;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_e;

endpackage

// File: rtl/fifo_sync.sv
// Circular byte FIFO with registered occupancy count and a sticky overflow flag.
module fifo_sync
    import uart_pkg::*;
#(
    parameter int unsigned DBIT   = DEF_DBIT,
    parameter int unsigned ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr,
    input  logic [DBIT-1:0]   w_data,
    input  logic              rd,
    output logic [DBIT-1:0]   r_data,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   count,
    output logic              overflow
);

    localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W + 1)'(2 ** ADDR_W);

    logic [DBIT-1:0]   mem [2 ** ADDR_W];
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              overflow_q, overflow_d;
    logic              do_push, do_pop;

    assign full   = (count_q == DEPTH_CNT);
    assign empty  = (count_q == '0);
    assign count  = count_q;
    assign overflow = overflow_q;
    assign r_data = mem[rd_ptr_q];

    // A simultaneous pop frees a slot, so a push at full is still accepted.
    assign do_pop  = rd && !empty;
    assign do_push = wr && (!full || do_pop);

    always_comb begin
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + ADDR_W'(1);
        end
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + ADDR_W'(1);
        end
        if (wr && !do_push) begin
            overflow_d = 1'b1;
        end
        unique case ({do_push, do_pop})
            2'b10:   count_d = count_q + (ADDR_W + 1)'(1);
            2'b01:   count_d = count_q - (ADDR_W + 1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage is intentionally not reset.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_q] <= w_data;
        end
    end

endmodule

// File: rtl/uart_tx_feeder.sv
// Buffers producer bytes and launches them one at a time into the UART transmitter.
module uart_tx_feeder
    import uart_pkg::*;
#(
    parameter int unsigned DBIT   = DEF_DBIT,
    parameter int unsigned ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr,
    input  logic [DBIT-1:0]   w_data,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    output logic              tx_start,
    output logic [DBIT-1:0]   din,
    input  logic              tx_done_tick,
    output logic              busy
);

    state_e          state_q, state_d;
    logic            tx_start_q, tx_start_d;
    logic [DBIT-1:0] din_q, din_d;
    logic [DBIT-1:0] r_data;
    logic            pop;

    fifo_sync #(
        .DBIT   (DBIT),
        .ADDR_W (ADDR_W)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .wr       (wr),
        .w_data   (w_data),
        .rd       (pop),
        .r_data   (r_data),
        .full     (full),
        .empty    (empty),
        .count    (count),
        .overflow (overflow)
    );

    always_comb begin
        state_d    = state_q;
        tx_start_d = 1'b0;
        din_d      = din_q;
        pop        = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!empty) begin
                    din_d      = r_data;
                    tx_start_d = 1'b1;
                    pop        = 1'b1;
                    state_d    = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (tx_done_tick) begin
                    state_d = ST_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            tx_start_q <= 1'b0;
            din_q      <= '0;
        end else begin
            state_q    <= state_d;
            tx_start_q <= tx_start_d;
            din_q      <= din_d;
        end
    end

    assign tx_start = tx_start_q;
    assign din      = din_q;
    assign busy     = (state_q == ST_WAIT);

endmodule
